// File: rtl/hall_pattern_gen.sv
// rtl/hall_pattern_gen.sv - three-channel Hall-sensor pattern generator with programmable step period
//
// Steps through the six 60-degree Hall sectors, one step every P clocks.
// A new period is staged in a pending register and only becomes active at a
// step boundary (or at once while stopped), so a running step is never
// shortened or stretched.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_reset          asynchronous active-high reset
//   i_enable         1 = run, 0 = freeze counter/sector, suppress pulses
//   i_dir            1 = forward (sector+1), 0 = reverse (sector-1)
//   i_period         requested clocks per step (clamped to >= 2 on capture)
//   i_load           strobe: capture i_period into the pending register
//   i_preset         strobe: force sector to i_preset_sector, clear counter
//   i_preset_sector  preset target; 6 and 7 map to 0
//   o_hall           registered Hall pattern {C,B,A}
//   o_sector         current sector 0..5
//   o_step           one-cycle pulse with each stepping change of o_hall
//   o_rev            one-cycle pulse on sector wrap
//   o_period_active  period currently governing the step length
module hall_pattern_gen #(
  parameter int CNT_W          = 24,
  parameter int DEFAULT_PERIOD = 1000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_dir,
  input  logic [CNT_W-1:0] i_period,
  input  logic             i_load,
  input  logic             i_preset,
  input  logic [2:0]       i_preset_sector,
  output logic [2:0]       o_hall,
  output logic [2:0]       o_sector,
  output logic             o_step,
  output logic             o_rev,
  output logic [CNT_W-1:0] o_period_active
);

  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  function automatic logic [2:0] hall_of(input logic [2:0] s);
    case (s)
      3'd0:    hall_of = 3'b001;
      3'd1:    hall_of = 3'b011;
      3'd2:    hall_of = 3'b010;
      3'd3:    hall_of = 3'b110;
      3'd4:    hall_of = 3'b100;
      3'd5:    hall_of = 3'b101;
      default: hall_of = 3'b001;
    endcase
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic [2:0]       sector_q, sector_d;
  logic [2:0]       hall_q, hall_d;
  logic             step_q, step_d;
  logic             rev_q, rev_d;

  logic [CNT_W-1:0] period_clamped;
  logic [2:0]       sector_adv;
  logic [2:0]       preset_sec;
  logic             wrap;
  logic             terminal;
  logic             boundary;

  assign period_clamped = (i_period < MIN_P) ? MIN_P : i_period;
  assign preset_sec     = (i_preset_sector > 3'd5) ? 3'd0 : i_preset_sector;
  assign wrap           = i_dir ? (sector_q == 3'd5) : (sector_q == 3'd0);
  assign sector_adv     = i_dir ? (wrap ? 3'd0 : sector_q + 3'd1)
                                : (wrap ? 3'd5 : sector_q - 3'd1);
  // >= rather than == so a period shrunk while stopped cannot leave the
  // counter stranded above the new terminal value.
  assign terminal       = (cnt_q >= active_q - ONE);
  // A step boundary only happens when running and not overridden by preset.
  assign boundary       = i_enable && !i_preset && terminal;

  always_comb begin
    cnt_d        = cnt_q;
    sector_d     = sector_q;
    hall_d       = hall_q;
    step_d       = 1'b0;
    rev_d        = 1'b0;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;

    if (i_preset) begin
      sector_d = preset_sec;
      hall_d   = hall_of(preset_sec);
      cnt_d    = '0;
    end else if (i_enable) begin
      if (terminal) begin
        cnt_d    = '0;
        sector_d = sector_adv;
        hall_d   = hall_of(sector_adv);
        step_d   = 1'b1;
        rev_d    = wrap;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end

    if (boundary) begin
      // A load on the boundary cycle bypasses the pending register.
      if (i_load) begin
        active_d = period_clamped;
      end else if (pend_valid_q) begin
        active_d = pend_q;
      end
      pend_valid_d = 1'b0;
    end else if (!i_enable && pend_valid_q) begin
      active_d     = pend_q;
      pend_valid_d = 1'b0;
    end

    if (i_load) begin
      pend_d = period_clamped;
      if (!boundary) begin
        pend_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q        <= '0;
      sector_q     <= 3'd0;
      hall_q       <= 3'b001;
      step_q       <= 1'b0;
      rev_q        <= 1'b0;
      active_q     <= DEF_P;
      pend_q       <= DEF_P;
      pend_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sector_q     <= sector_d;
      hall_q       <= hall_d;
      step_q       <= step_d;
      rev_q        <= rev_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign o_hall          = hall_q;
  assign o_sector        = sector_q;
  assign o_step          = step_q;
  assign o_rev           = rev_q;
  assign o_period_active = active_q;

endmodule

// File: doc/hall_pattern_gen.md
Name: hall_pattern_gen

Overview:
Generates a three-channel Hall-sensor waveform (120° sensor placement) at a programmable step rate. It is the transmit-side counterpart of the Hall edge-detection and speed-measurement path. It drives the controller's Hall inputs for closed-loop bench testing and for sensorless open-loop start-up emulation. One electrical revolution is six steps of i_period clocks each.

Parameters:
CNT_W, 24, width of the period and step counter
DEFAULT_PERIOD, 1000, period loaded at reset (clocks per 60° step); must be >= 2

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_reset  in  1  asynchronous, active-high reset
i_enable  in  1  1 = run the pattern, 0 = freeze counter and outputs
i_dir  in  1  1 = forward (sector increments), 0 = reverse (sector decrements)
i_period  in  CNT_W  requested clocks per step
i_load  in  1  one-cycle strobe; captures i_period into the pending register
i_preset  in  1  one-cycle strobe; force the sector to i_preset_sector
i_preset_sector  in  3  sector value for a preset, 0..5
o_hall  out  3  Hall pattern {C,B,A}
o_sector  out  3  current sector 0..5
o_step  out  1  one-cycle pulse, coincident with each o_hall change caused by stepping
o_rev  out  1  one-cycle pulse when the sector wraps (5->0 forward, 0->5 reverse)
o_period_active  out  CNT_W  period currently in use

Behaviour:
- Reset (async, i_reset=1):
  - sector=0, o_hall=3'b001, counter=0
  - o_step=0, o_rev=0
  - active and pending period = DEFAULT_PERIOD; pending-valid flag cleared
- Hall map by sector (registered outputs, no combinational decode glitches):
  - 0:001, 1:011, 2:010, 3:110, 4:100, 5:101
  - Exactly one bit changes per step, in either direction.
- Period clamp: any value < 2 is replaced by 2 on capture.
- i_load:
  - Clamped i_period goes into the pending register; pending-valid is set.
  - A later i_load before the pending value is applied overwrites it.
- Pending apply:
  - While running, the pending period is applied only at a step boundary, so the current step is never shortened or stretched.
  - If i_enable=0, the pending period is applied on the next clock.
  - When applied, pending-valid is cleared.
- Counting (i_enable=1):
  - Counter runs 0..P-1, where P is the active period.
  - At counter==P-1 (terminal):
    - Counter returns to 0.
    - Sector advances per i_dir as sampled on that cycle, wrapping modulo 6.
    - o_hall and o_sector update on the same edge.
    - o_step=1 for exactly that cycle.
    - o_rev=1 on a wrap.
    - Any pending period becomes active for the new step.
  - Step spacing is therefore exactly P clocks.
- A direction change mid-step takes effect only at the next boundary; the counter is not reset.
- i_enable=0:
  - Counter, sector and o_hall hold.
  - o_step and o_rev are forced to 0.
  - Re-enable resumes from the held count with no restart.
- i_preset:
  - Sector = i_preset_sector (6 or 7 maps to 0).
  - o_hall is updated and the counter is cleared.
  - No o_step or o_rev pulse.
  - Acts regardless of i_enable.
- Simultaneous events:
  - i_preset with terminal: preset wins, no step pulse.
  - i_load with terminal: the newly loaded value is the one applied to the step that begins.
  - i_load with i_preset: both take effect.
- Async reset mid-step: outputs return to reset values immediately. Counting restarts from 0 after release if enabled.
- o_step/o_rev pulses are one clock wide, suitable for the downstream edge detector sampling on the opposite clock edge.

Test Plan:
- Reset, then load period 4, enable, dir=1:
  - o_hall sequence 001,011,010,110,100,101,001
  - o_step every 4 clocks
  - o_rev once at the 101->001 transition
- dir=0 from sector 0, period 4:
  - o_hall 001->101->100->110->010->011->001
  - o_rev on the first step (0->5)
- Load period 10 two clocks into a 4-clock step:
  - current step still ends at 4 clocks
  - next step spacing is 10
  - o_period_active changes at the boundary
- Load period 0 or 1:
  - o_period_active becomes 2
  - o_step every 2 clocks, no gaps or doubles
- Disable for 7 clocks mid-step:
  - o_hall frozen, no o_step
  - on re-enable, the remaining count completes before the next step
- Preset sector 3 coincident with terminal count:
  - o_hall=110, no o_step
  - next step after P clocks gives 100
  - then assert i_reset mid-step: o_hall=001 immediately
